// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with relative/absolute branches and an optional
// circular return-address stack, enabled by defining FETCH_PC_RAS_EN.
module fetch_pc_unit #(
  parameter int D         = 12,
  parameter int OFFW      = 3,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         Init,
  input  logic                         Halt,
  input  logic                         Branch,
  input  logic                         PCSrc,
  input  logic [1:0]                   BrMode,
  input  logic [OFFW-1:0]              Offset,
  input  logic [D-1:0]                 Target,
  output logic [D-1:0]                 PC,
  output logic                         Done,
  output logic [$clog2(RAS_DEPTH):0]   RasCount,
  output logic                         RasOvf,
  output logic                         RasUnf
);

  typedef enum logic [1:0] {
    BR_REL  = 2'b00,
    BR_ABS  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_mode_e;

  logic [D-1:0] r_pc;
  logic         r_done;
  logic         w_rst;
  logic         w_taken;
  br_mode_e     w_mode;
  logic [D-1:0] w_pc_inc;
  logic [D-1:0] w_off;
  logic [D-1:0] w_pc_nxt;
  logic         w_ras_hit;
  logic [D-1:0] w_ras_top;

  assign w_rst    = reset | Init;
  assign w_taken  = Branch & PCSrc;
  assign w_mode   = br_mode_e'(BrMode);
  assign w_pc_inc = r_pc + 1'b1;
  assign w_off    = D'($signed(Offset));

`ifdef FETCH_PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [D-1:0]  r_ras [RAS_DEPTH];
  logic [PW-1:0] r_top;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_unf;
  logic [PW-1:0] w_top_inc;
  logic          w_push;
  logic          w_pop;
  logic          w_under;
  logic          w_full;

  assign w_top_inc = r_top + 1'b1;
  assign w_full    = (r_cnt == CW'(RAS_DEPTH));
  assign w_push    = ~w_rst & ~Halt & w_taken & (w_mode == BR_CALL);
  assign w_pop     = ~w_rst & ~Halt & w_taken & (w_mode == BR_RET) & (r_cnt != '0);
  assign w_under   = ~w_rst & ~Halt & w_taken & (w_mode == BR_RET) & (r_cnt == '0);
  assign w_ras_hit = (r_cnt != '0);
  assign w_ras_top = r_ras[r_top];

  // Pointer always advances on push, so a full stack overwrites its oldest slot.
  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_push) begin
      r_top <= w_top_inc;
      if (w_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + 1'b1;
    end else if (w_pop) begin
      r_top <= r_top - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end else if (w_under) begin
      r_unf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_ras[w_top_inc] <= w_pc_inc;
  end

  assign RasCount = r_cnt;
  assign RasOvf   = r_ovf;
  assign RasUnf   = r_unf;
`else
  assign w_ras_hit = 1'b0;
  assign w_ras_top = w_pc_inc;
  assign RasCount  = '0;
  assign RasOvf    = 1'b0;
  assign RasUnf    = 1'b0;
`endif

  always_comb begin
    w_pc_nxt = w_pc_inc;
    if (w_taken) begin
      unique case (w_mode)
        BR_REL:  w_pc_nxt = r_pc + w_off;
        BR_ABS:  w_pc_nxt = Target;
        BR_CALL: w_pc_nxt = Target;
        BR_RET:  w_pc_nxt = w_ras_hit ? w_ras_top : w_pc_inc;
        default: w_pc_nxt = w_pc_inc;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_rst) begin
      r_pc   <= '0;
      r_done <= 1'b0;
    end else if (Halt) begin
      r_done <= 1'b1;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign PC   = r_pc;
  assign Done = r_done;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a queue-based reference model; follows
// FETCH_PC_RAS_EN so the same bench covers both builds.
module tb_fetch_pc_unit;
  localparam int D         = 12;
  localparam int OFFW      = 3;
  localparam int RAS_DEPTH = 4;
  localparam int MOD       = 1 << D;

  logic                       CLK = 1'b0;
  logic                       reset = 1'b0, Init = 1'b0, Halt = 1'b0;
  logic                       Branch = 1'b0, PCSrc = 1'b0;
  logic [1:0]                 BrMode = 2'b00;
  logic [OFFW-1:0]            Offset = '0;
  logic [D-1:0]               Target = '0;
  logic [D-1:0]               PC;
  logic                       Done;
  logic [$clog2(RAS_DEPTH):0] RasCount;
  logic                       RasOvf, RasUnf;

  fetch_pc_unit #(.D(D), .OFFW(OFFW), .RAS_DEPTH(RAS_DEPTH)) dut (
    .CLK(CLK), .reset(reset), .Init(Init), .Halt(Halt), .Branch(Branch),
    .PCSrc(PCSrc), .BrMode(BrMode), .Offset(Offset), .Target(Target),
    .PC(PC), .Done(Done), .RasCount(RasCount), .RasOvf(RasOvf), .RasUnf(RasUnf)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer, RAS as a bounded queue
  int m_pc = 0;
  bit m_done = 0, m_ovf = 0, m_unf = 0, m_valid = 0;
  int stk[$];

  always @(posedge CLK) begin
    int off;
    if (reset || Init) begin
      m_pc = 0; m_done = 0; m_ovf = 0; m_unf = 0; m_valid = 1;
      stk.delete();
    end else if (Halt) begin
      m_done = 1;
    end else if (m_valid) begin
      if (Branch && PCSrc) begin
        case (BrMode)
          2'b00: begin
            off  = int'($signed(Offset));
            m_pc = (m_pc + off + MOD) % MOD;
          end
          2'b01: m_pc = int'(Target);
`ifdef FETCH_PC_RAS_EN
          2'b10: begin
            if (stk.size() == RAS_DEPTH) begin
              void'(stk.pop_front());
              m_ovf = 1;
            end
            stk.push_back((m_pc + 1) % MOD);
            m_pc = int'(Target);
          end
          default: begin
            if (stk.size() > 0) m_pc = stk.pop_back();
            else begin
              m_pc  = (m_pc + 1) % MOD;
              m_unf = 1;
            end
          end
`else
          2'b10: m_pc = int'(Target);
          default: m_pc = (m_pc + 1) % MOD;
`endif
        endcase
      end else begin
        m_pc = (m_pc + 1) % MOD;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("pc", int'(PC), m_pc);
      chk("done", int'(Done), int'(m_done));
      chk("rascount", int'(RasCount), stk.size());
      chk("rasovf", int'(RasOvf), int'(m_ovf));
      chk("rasunf", int'(RasUnf), int'(m_unf));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
    chk({nm, "_dut"}, dut_v, exp);
    chk({nm, "_model"}, mdl_v, exp);
  endtask

  task automatic br(input logic [1:0] mode, input logic [OFFW-1:0] off, input logic [D-1:0] tgt);
    Branch = 1'b1; PCSrc = 1'b1; BrMode = mode; Offset = off; Target = tgt;
  endtask

  task automatic nobr();
    Branch = 1'b0; PCSrc = 1'b0; BrMode = 2'b00; Offset = '0; Target = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

`ifdef FETCH_PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  initial begin
    // Reset and free run
    @(negedge CLK);
    do_reset();
    lit("reset_pc", int'(PC), m_pc, 0);
    lit("reset_done", int'(Done), int'(m_done), 0);
    repeat (5) tick();
    lit("freerun_pc", int'(PC), m_pc, 5);

    // Signed relative branch
    repeat (5) tick();
    br(2'b00, 3'b101, '0); tick(); nobr();
    lit("rel_neg3", int'(PC), m_pc, 7);
    do_reset();
    br(2'b00, 3'b111, '0); tick(); nobr();
    lit("rel_wrap_low", int'(PC), m_pc, 'hFFF);
    tick();
    lit("seq_wrap_high", int'(PC), m_pc, 0);
    br(2'b00, 3'b011, '0); PCSrc = 1'b0; tick(); nobr();
    lit("not_taken", int'(PC), m_pc, 1);

    // Absolute jump, halt with a branch (and a call) pending
    repeat (19) tick();
    br(2'b01, '0, 12'h100); tick();
    lit("abs_jump", int'(PC), m_pc, 'h100);
    Halt = 1'b1; tick();
    br(2'b10, '0, 12'h200); tick();
    lit("halt_pc", int'(PC), m_pc, 'h100);
    lit("halt_done", int'(Done), int'(m_done), 1);
    lit("halt_ras", int'(RasCount), stk.size(), 0);
    Halt = 1'b0; nobr(); tick();
    lit("resume_pc", int'(PC), m_pc, 'h101);
    lit("resume_done", int'(Done), int'(m_done), 1);

    // Nested calls and returns
    do_reset();
    repeat (5) tick();
    br(2'b10, '0, 12'd40); tick();
    br(2'b10, '0, 12'd80); tick();
    lit("call_cnt", int'(RasCount), stk.size(), RAS ? 2 : 0);
    br(2'b11, '0, 12'd999); tick();
    lit("ret1", int'(PC), m_pc, RAS ? 41 : 81);
    tick();
    lit("ret2", int'(PC), m_pc, RAS ? 6 : 82);
    lit("ret2_cnt", int'(RasCount), stk.size(), 0);
    tick(); nobr();
    lit("ret3_pc", int'(PC), m_pc, RAS ? 7 : 83);
    lit("ret3_unf", int'(RasUnf), int'(m_unf), RAS ? 1 : 0);

    // Overflow: calls from PCs 1..5 each targeting the next PC
    do_reset();
    tick();
    for (int i = 1; i <= 5; i++) begin
      br(2'b10, '0, D'(i + 1)); tick();
    end
    lit("ovf_pc", int'(PC), m_pc, 6);
    lit("ovf_cnt", int'(RasCount), stk.size(), RAS ? 4 : 0);
    lit("ovf_flag", int'(RasOvf), int'(m_ovf), RAS ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      br(2'b11, '0, '0); tick();
      lit("ovf_ret", int'(PC), m_pc, RAS ? 6 - i : 7 + i);
    end
    nobr();

    // Init mid-operation with live stack and sticky flags
    br(2'b11, '0, '0); tick();
    for (int i = 0; i < 3; i++) begin
      br(2'b10, '0, D'(100 + 10 * i)); tick();
    end
    nobr();
    Halt = 1'b1; tick();
    lit("pre_init_cnt", int'(RasCount), stk.size(), RAS ? 3 : 0);
    lit("pre_init_done", int'(Done), int'(m_done), 1);
    Init = 1'b1; tick(); Init = 1'b0; Halt = 1'b0;
    lit("init_pc", int'(PC), m_pc, 0);
    lit("init_done", int'(Done), int'(m_done), 0);
    lit("init_cnt", int'(RasCount), stk.size(), 0);
    lit("init_ovf", int'(RasOvf), int'(m_ovf), 0);
    lit("init_unf", int'(RasUnf), int'(m_unf), 0);
    br(2'b11, '0, '0); tick(); nobr();
    lit("post_init_ret", int'(PC), m_pc, 1);
    lit("post_init_unf", int'(RasUnf), int'(m_unf), RAS ? 1 : 0);
    tick();

    @(negedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter unit for the processor's fetch stage. It replaces the fixed 12-bit PC with a configurable-width PC that supports signed relative branches, absolute jumps, and subroutine call/return through an optional hardware return-address stack (RAS). Control and branch-resolution logic drive it, and it feeds the instruction-memory address. It also provides a registered `Done` flag for the testbench handshake.

## Interface
- `D`, 12, PC width in bits; PC arithmetic is modulo 2^D.
- `OFFW`, 3, width of the signed relative branch offset; `OFFW` ≤ `D`.
- `RAS_DEPTH`, 4, number of RAS entries; must be a power of two and at least 2.

- `CLK`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Init`  in  1  synchronous program restart; same effect as `reset`.
- `Halt`  in  1  freeze PC and raise `Done`.
- `Branch`  in  1  current instruction is a control-transfer instruction.
- `PCSrc`  in  1  branch condition is true.
- `BrMode`  in  2  transfer type: 00 relative, 01 absolute, 10 call, 11 return.
- `Offset`  in  OFFW  signed two's-complement relative offset.
- `Target`  in  D  absolute target for absolute jumps and calls.
- `PC`  out  D  current fetch address.
- `Done`  out  1  registered halt indication.
- `RasCount`  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `RasOvf`  out  1  sticky flag: a push discarded an entry.
- `RasUnf`  out  1  sticky flag: a pop was attempted on an empty RAS.

## Operation
- A branch is taken when `Branch && PCSrc`.
- Priority per cycle: `reset`/`Init` > `Halt` > taken branch > sequential.
- `reset` or `Init`:
  - `PC`=0, `Done`=0, `RasCount`=0, `RasOvf`=0, `RasUnf`=0.
  - RAS contents become don't-care.
- `Halt`:
  - `PC` holds; `Done` is set to 1 and stays set until `reset`/`Init`.
  - The RAS does not change, even if `Branch` is asserted in the same cycle.
  - Deasserting `Halt` resumes execution from the held `PC`; `Done` stays 1.
- Sequential (no taken branch): `PC` <= `PC`+1, wrapping from 2^D−1 to 0.
- Relative (00): `PC` <= `PC` + sign-extended `Offset`, modulo 2^D.
  - Example with D=12: offset −1 at PC=0 gives 0xFFF.
- Absolute (01): `PC` <= `Target`.
- Call (10):
  - Push `PC`+1 (mod 2^D) onto the RAS, then `PC` <= `Target`.
  - RAS is circular. When full, the push overwrites the oldest entry, `RasCount` stays at `RAS_DEPTH`, and `RasOvf` is set.
- Return (11):
  - If `RasCount` > 0: `PC` <= top entry and `RasCount` decrements.
  - If `RasCount` = 0: `PC` <= `PC`+1, `RasUnf` is set, and the RAS is unchanged.
- When the branch is not taken, `BrMode`, `Offset` and `Target` are ignored.
- The RAS is a pointer-indexed register array. The top-of-stack pointer wraps modulo `RAS_DEPTH`.

## Timing
- Every output is registered. There is no combinational path from inputs to outputs.
- A decision sampled at edge N is visible on `PC` after edge N.
- The fetch address has single-cycle latency; there are no bubbles.
- `Done` rises on the edge that samples `Halt`=1, at the same time `PC` freezes.
- A call at edge N followed by a return at edge N+1 returns to the call's `PC`+1 at edge N+1. The push/pop bypass is internal to the stack state.
- `reset` applied mid-call-chain clears everything on that edge. A return on the next cycle is then an underflow.

## Configuration
- Macro `FETCH_PC_RAS_EN`.
- Defined: the RAS, `RasCount`, `RasOvf` and `RasUnf` behave as described above.
- Undefined:
  - No RAS storage is built.
  - Call (10) behaves as absolute: `PC` <= `Target`, no push.
  - Return (11) behaves as sequential: `PC`+1, with no underflow flag.
  - `RasCount`, `RasOvf` and `RasUnf` are tied to 0.

## Test plan
- Reset then free run, D=12: hold `reset` 2 cycles, then 5 idle cycles -> `PC` = 0,1,2,3,4,5; `Done`=0.
- Signed relative branch: at `PC`=10, `Branch`=`PCSrc`=1, mode 00, `Offset`=3'b101 (−3) -> `PC`=7.
  - At `PC`=0 with `Offset`=−1 -> `PC`=0xFFF.
- Absolute jump vs. halt: at `PC`=20, mode 01, `Target`=0x100 -> `PC`=0x100.
  - `Halt` with `Branch` also asserted -> `PC` holds at 0x100 and `Done`=1.
  - Release `Halt` -> `PC`=0x101 and `Done` stays 1.
- Nested calls (`FETCH_PC_RAS_EN`, depth 4):
  - Call from `PC`=5 to 40, then call from 40 to 80 -> `RasCount`=2.
  - Return -> `PC`=41. Return -> `PC`=6, `RasCount`=0.
  - A third return -> `PC`=7, `RasUnf`=1.
- Overflow: 5 consecutive calls from `PC`s 1,2,3,4,5 -> `RasCount`=4 and `RasOvf`=1.
  - 4 returns yield 6,5,4,3 in that order; the entry pushed by the call from `PC`=1 has been discarded.
- `Init` mid-operation: with `RasCount`=3 and `Done`=1, pulse `Init` -> next cycle `PC`=0, `Done`=0, `RasCount`=0, flags cleared.
  - Repeat the test with the macro undefined: call acts as jump, return acts as +1.
